// File: rtl/pixel_row_readout_pkg.sv
// Shared sensor configuration and readout types for pixel_row_readout.
// Holds the pixel array geometry, derived widths, the ping-pong buffer
// depth and the read-side FSM state encoding.
package pixel_row_readout_pkg;

  localparam int PIXEL_ARRAY_WIDTH  = 2;
  localparam int PIXEL_ARRAY_HEIGHT = 2;
  localparam int PIXEL_BITS         = 8;

  // Number of row buffers in the ping-pong store.
  localparam int READOUT_BUFFERS = 2;

  // Widths are clamped to 1 so a 1-wide or 1-high array still elaborates.
  localparam int ROW_IDX_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
  localparam int COL_W     = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1;

  // One full row as seen on the column bus: column c is element [c].
  typedef logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] pixel_row_t;

  typedef enum logic {
    READOUT_IDLE,
    READOUT_STREAM
  } readout_state_e;

endpackage

// File: rtl/pixel_row_readout_row_ping_pong_buffer.sv
// Two-entry row store for pixel_row_readout.
// Each entry holds one captured row plus the row index it was captured with.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en_i      write the row into entry wr_ptr_i
//   wr_ptr_i     entry selected for writing
//   wr_row_i     row pixel codes to store
//   wr_idx_i     row index stored alongside the row
//   rd_ptr_i     entry selected for reading
//   rd_col_i     column selected within the read entry
//   rd_data_o    pixel code at [rd_ptr_i][rd_col_i]
//   rd_idx_o     row index stored in entry rd_ptr_i
module pixel_row_readout_row_ping_pong_buffer
  import pixel_row_readout_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en_i,
  input  logic                 wr_ptr_i,
  input  pixel_row_t           wr_row_i,
  input  logic [ROW_IDX_W-1:0] wr_idx_i,
  input  logic                 rd_ptr_i,
  input  logic [COL_W-1:0]     rd_col_i,
  output logic [PIXEL_BITS-1:0] rd_data_o,
  output logic [ROW_IDX_W-1:0] rd_idx_o
);

  pixel_row_t           row_q [READOUT_BUFFERS];
  logic [ROW_IDX_W-1:0] idx_q [READOUT_BUFFERS];

  // NOTE: this store is only two rows of flops, so it is reset like any
  // other register; the read mux then never presents X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < READOUT_BUFFERS; b++) begin
        row_q[b] <= '0;
        idx_q[b] <= '0;
      end
    end else if (wr_en_i) begin
      row_q[wr_ptr_i] <= wr_row_i;
      idx_q[wr_ptr_i] <= wr_idx_i;
    end
  end

  assign rd_data_o = row_q[rd_ptr_i][rd_col_i];
  assign rd_idx_o  = idx_q[rd_ptr_i];

endmodule

// File: rtl/pixel_row_readout.sv
// Row readout: delays each row strobe by CAPTURE_DELAY cycles, captures the
// column bus into a ping-pong row buffer and streams buffered rows to the
// host one pixel per beat with row-last / frame-start markers.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   new_row_i           one-cycle row strobe
//   frame_finished_i    end-of-frame pulse, clears the row index
//   pixel_data_i        column bus, column c at [c*PIXEL_BITS +: PIXEL_BITS]
//   out_data_o          current pixel code
//   out_valid_o         beat valid
//   out_ready_i         sink accepts the beat
//   out_row_last_o      beat is the last column of its row
//   out_frame_start_o   beat is column 0 of row index 0
//   out_row_index_o     row index of the current beat
//   overflow_o          sticky: a row or strobe was dropped
module pixel_row_readout
  import pixel_row_readout_pkg::*;
#(
  parameter int CAPTURE_DELAY = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   new_row_i,
  input  logic                                   frame_finished_i,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] pixel_data_i,
  output logic [PIXEL_BITS-1:0]                  out_data_o,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic                                   out_row_last_o,
  output logic                                   out_frame_start_o,
  output logic [ROW_IDX_W-1:0]                   out_row_index_o,
  output logic                                   overflow_o
);

  localparam logic [2:0]           DELAY_LOAD = 3'(CAPTURE_DELAY);
  localparam logic [COL_W-1:0]     LAST_COL   = COL_W'(PIXEL_ARRAY_WIDTH - 1);
  localparam logic [ROW_IDX_W-1:0] LAST_ROW   = ROW_IDX_W'(PIXEL_ARRAY_HEIGHT - 1);
  localparam logic [1:0]           FULL       = 2'(READOUT_BUFFERS);

  // Capture side. delay_q == 0 means no capture pending; a strobe loads it
  // and the capture happens on the edge that sees it at 1.
  logic [2:0]           delay_q, delay_d;
  logic [ROW_IDX_W-1:0] row_idx_q, row_idx_d;
  logic [1:0]           count_q, count_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 overflow_q, overflow_d;

  // Read side.
  readout_state_e       state_q, state_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [PIXEL_BITS-1:0] out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic                 out_fs_q, out_fs_d;
  logic [ROW_IDX_W-1:0] out_idx_q, out_idx_d;

  logic                  capture_fire, accept, release_row, load_beat;
  logic [PIXEL_BITS-1:0] rd_data;
  logic [ROW_IDX_W-1:0]  rd_idx;

  assign capture_fire = (delay_q == 3'd1);
  // With both buffers full, a row finishing on this same edge frees a slot
  // in time for the capture.
  assign accept = capture_fire && ((count_q != FULL) || release_row);

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    delay_d    = delay_q;
    row_idx_d  = row_idx_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;

    if (delay_q != 3'd0) begin
      delay_d = delay_q - 3'd1;
    end else if (new_row_i) begin
      delay_d = DELAY_LOAD;
    end

    // Dropped rows still consume a row index.
    if (capture_fire) begin
      row_idx_d = (row_idx_q == LAST_ROW) ? '0 : row_idx_q + ROW_IDX_W'(1);
    end
    // Frame end wins over the increment; a same-edge capture has already
    // used the old index.
    if (frame_finished_i) begin
      row_idx_d = '0;
    end

    if (accept) begin
      wr_ptr_d = ~wr_ptr_q;
    end

    if ((new_row_i && (delay_q != 3'd0)) || (capture_fire && !accept)) begin
      overflow_d = 1'b1;
    end

    count_d = count_q + 2'(accept) - 2'(release_row);
  end

  // Read FSM. The buffer is addressed with the next-beat pointer/column so
  // the output registers load the upcoming beat on the same edge.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    rd_ptr_d    = rd_ptr_q;
    load_beat   = 1'b0;
    release_row = 1'b0;

    case (state_q)
      READOUT_IDLE: begin
        if (count_q != 2'd0) begin
          state_d   = READOUT_STREAM;
          col_d     = '0;
          load_beat = 1'b1;
        end
      end
      READOUT_STREAM: begin
        if (out_ready_i) begin
          if (col_q == LAST_COL) begin
            release_row = 1'b1;
            rd_ptr_d    = ~rd_ptr_q;
            col_d       = '0;
            // Only a row already stored can be streamed back-to-back; one
            // captured on this edge is picked up from IDLE next cycle.
            if (count_q == FULL) begin
              load_beat = 1'b1;
            end else begin
              state_d = READOUT_IDLE;
            end
          end else begin
            col_d     = col_q + COL_W'(1);
            load_beat = 1'b1;
          end
        end
      end
      default: state_d = READOUT_IDLE;
    endcase
  end

  always_comb begin
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_fs_d   = out_fs_q;
    out_idx_d  = out_idx_q;
    if (load_beat) begin
      out_data_d = rd_data;
      out_last_d = (col_d == LAST_COL);
      out_fs_d   = (col_d == '0) && (rd_idx == '0);
      out_idx_d  = rd_idx;
    end else if (state_d == READOUT_IDLE) begin
      out_last_d = 1'b0;
      out_fs_d   = 1'b0;
    end
  end

  pixel_row_readout_row_ping_pong_buffer u_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (accept),
    .wr_ptr_i  (wr_ptr_q),
    .wr_row_i  (pixel_data_i),
    .wr_idx_i  (row_idx_q),
    .rd_ptr_i  (rd_ptr_d),
    .rd_col_i  (col_d),
    .rd_data_o (rd_data),
    .rd_idx_o  (rd_idx)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_q    <= '0;
      row_idx_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= READOUT_IDLE;
      col_q      <= '0;
      rd_ptr_q   <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_fs_q   <= 1'b0;
      out_idx_q  <= '0;
    end else begin
      delay_q    <= delay_d;
      row_idx_q  <= row_idx_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      col_q      <= col_d;
      rd_ptr_q   <= rd_ptr_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_fs_q   <= out_fs_d;
      out_idx_q  <= out_idx_d;
    end
  end

  assign out_valid_o       = (state_q == READOUT_STREAM);
  assign out_data_o        = out_data_q;
  assign out_row_last_o    = out_last_q;
  assign out_frame_start_o = out_fs_q;
  assign out_row_index_o   = out_idx_q;
  assign overflow_o        = overflow_q;

endmodule

// File: doc/pixel_row_readout.md
# pixel_row_readout

Downstream consumer of the sensor state controller. Each row strobe delays by a settle interval, then captures one full row of pixel codes from the shared column bus into a two-entry ping-pong row buffer. Buffered rows are serialised to the host one pixel per beat over a valid/ready stream, with row and frame markers. Rows that arrive while both buffers are occupied are dropped and flagged, never silently overwritten.

## Interface
Parameters:
- CAPTURE_DELAY, 2: cycles from a NEW_ROW sample to the PIXEL_DATA capture. Legal range 1..4; must be less than the row read period of 5.
- PIXEL_ARRAY_WIDTH, PIXEL_ARRAY_HEIGHT, PIXEL_BITS: imported from PixelSensorConfig.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low. Low clears all state immediately.
- NEW_ROW  in  1  row strobe from the sensor state controller; one-cycle pulse.
- FRAME_FINISHED  in  1  end-of-frame pulse from the sensor state controller.
- PIXEL_DATA  in  PIXEL_ARRAY_WIDTH*PIXEL_BITS  column bus; column c occupies bits [c*PIXEL_BITS +: PIXEL_BITS].
- OUT_DATA  out  PIXEL_BITS  current pixel code.
- OUT_VALID  out  1  OUT_DATA holds a valid beat.
- OUT_READY  in  1  sink accepts the beat.
- OUT_ROW_LAST  out  1  beat is column PIXEL_ARRAY_WIDTH-1.
- OUT_FRAME_START  out  1  beat is column 0 of row index 0.
- OUT_ROW_INDEX  out  $clog2(PIXEL_ARRAY_HEIGHT)  row index of the current beat.
- OVERFLOW  out  1  sticky; set when a row is dropped.

## Operation
Capture side:
- NEW_ROW high at edge k loads the delay counter. PIXEL_DATA is captured at edge k+CAPTURE_DELAY.
- A NEW_ROW sample while a capture is pending is ignored and sets OVERFLOW.
- At the capture edge:
  - If fewer than 2 rows are stored: write the row into buffer wr_ptr together with the current row index, toggle wr_ptr, increment count.
  - If 2 rows are stored: drop the row and set OVERFLOW.
  - In both cases the row index increments, wrapping at PIXEL_ARRAY_HEIGHT-1 to 0.
- FRAME_FINISHED clears the row index to 0 at the next edge and does not flush buffered rows. If FRAME_FINISHED and a capture occur on the same edge, the capture uses the old index and the index then becomes 0.

Read side FSM:
- IDLE:
  - OUT_VALID is 0.
  - Go to STREAM when count > 0, with column = 0.
- STREAM:
  - OUT_VALID is 1. OUT_DATA = buffer[rd_ptr] column.
  - On OUT_VALID & OUT_READY, column increments.
  - On the beat with OUT_ROW_LAST: toggle rd_ptr and decrement count. Stay in STREAM with column 0 if another row is buffered; otherwise go to IDLE.
- Simultaneous release and capture with count==2: the release takes effect first and the capture is accepted. The count stays 2.
- Simultaneous release and capture with count==1: the count stays 1.

Outputs:
- OUT_DATA, OUT_ROW_LAST, OUT_FRAME_START and OUT_ROW_INDEX hold stable while OUT_VALID & !OUT_READY.
- OVERFLOW clears only on reset.

## Timing
- Reset values: OUT_VALID 0, OUT_DATA 0, OUT_ROW_LAST 0, OUT_FRAME_START 0, OUT_ROW_INDEX 0, OVERFLOW 0. Internally: count 0, wr_ptr 0, rd_ptr 0, delay counter idle, FSM IDLE.
- Latency: NEW_ROW sampled at edge k with the buffer empty gives OUT_VALID high after edge k+CAPTURE_DELAY+1.
- Throughput: one beat per cycle while OUT_READY is held high.
- A row of PIXEL_ARRAY_WIDTH beats therefore drains within the 5-cycle strobe period only if PIXEL_ARRAY_WIDTH ≤ 5. Wider arrays rely on the second buffer.
- All outputs are registered; there is no combinational path from OUT_READY to OUT_VALID.
- Reset asserted mid-row abandons the row immediately. After RESET returns high, the first strobe starts fresh at row index 0.

## Structure
- PixelSensorConfig package:
  - Add the read FSM typedef (READOUT_IDLE, READOUT_STREAM).
  - Add a constant READOUT_BUFFERS = 2.
- Sub-module row_ping_pong_buffer:
  - Two row registers with stored row indices.
  - Write port: wr_en, wr_ptr, data.
  - Read port: rd_ptr, column mux.
  - Async active-low reset.
- Top level holds:
  - delay counter
  - row index counter
  - count and pointers
  - read FSM
  - output registers

## Test plan
Parameters for all scenarios: WIDTH=2, HEIGHT=2, BITS=8, CAPTURE_DELAY=2.
- Single row: PIXEL_DATA=16'hB2A1, NEW_ROW at edge 10, OUT_READY=1 → OUT_VALID rises after edge 13. Beats are A1 then B2. OUT_FRAME_START on A1, OUT_ROW_LAST on B2, OUT_ROW_INDEX 0.
- Backpressure: OUT_READY low for 3 cycles mid-row → OUT_DATA stays A1 and OUT_VALID stays 1. No beat is lost or duplicated.
- Overflow: OUT_READY=0 with three strobes 5 cycles apart → rows 0 and 1 are buffered, the third is dropped, and OVERFLOW is 1. Releasing OUT_READY streams rows 0 then 1 only.
- Frame wrap: two strobes, FRAME_FINISHED, one strobe → OUT_ROW_INDEX is 0, 1, 0, and OUT_FRAME_START is asserted on the first and third rows.
- Strobe during delay: NEW_ROW at edges 10 and 11 → one row captured and OVERFLOW set.
- Reset mid-row: RESET low during beat 1 → all outputs are at reset values within the same cycle. The next strobe after RESET returns high streams at row index 0.
